// File: rtl/grid_gen_sequencer.sv
// Sequences one grid generator per request: seeds it, starts it, waits for done, retries with LFSR seeds.
// Optional lifetime statistics counters are enabled with `define GRID_SEQ_STATS_EN.
module grid_gen_sequencer #(
  parameter int         MAX_ATTEMPTS   = 8,
  parameter int         TIMEOUT_CYCLES = 22500,
  parameter int         START_PULSE    = 4,
  parameter logic [7:0] SEED_INIT      = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  output logic        busy,
  output logic        result_valid,
  output logic        result_ok,
  output logic [3:0]  attempts,
  output logic [7:0]  seed,
  output logic        gen_reset,
  output logic        gen_rq_start,
  input  logic        gen_done,
  input  logic        gen_success,
  output logic [15:0] total_attempts,
  output logic [15:0] total_timeouts
);

  typedef enum logic [2:0] {IDLE, RESET_GEN, START, WAIT, CHECK, REPORT} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > START_PULSE) ? TIMEOUT_CYCLES : START_PULSE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    att_cnt;
  logic          done_prev;
  logic          succ;
  logic          adv_lfsr;
  logic          done_edge;
  logic          wait_timeout;
  logic          start_last;
  logic [7:0]    lfsr_next;

  assign lfsr_next  = {1'b0, seed[7:1]} ^ (seed[0] ? 8'hB8 : 8'h00);
  assign start_last = (cnt == CW'(START_PULSE - 1));

  always_comb begin
    state_n      = state;
    adv_lfsr     = 1'b0;
    done_edge    = 1'b0;
    wait_timeout = 1'b0;
    busy         = (state != IDLE);
    result_valid = (state == REPORT);
    gen_reset    = (state == RESET_GEN);
    gen_rq_start = (state == START);
    case (state)
      IDLE:      if (req) state_n = RESET_GEN;
      RESET_GEN: state_n = START;
      START:     if (start_last) state_n = WAIT;
      WAIT: begin
        if (gen_done && !done_prev) begin
          done_edge = 1'b1;
          state_n   = CHECK;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          wait_timeout = 1'b1;
          state_n      = CHECK;
        end
      end
      CHECK: begin
        if (succ || att_cnt == 4'(MAX_ATTEMPTS)) state_n = REPORT;
        else begin
          adv_lfsr = 1'b1;
          state_n  = RESET_GEN;
        end
      end
      REPORT: begin
        adv_lfsr = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      att_cnt   <= '0;
      done_prev <= 1'b0;
      succ      <= 1'b0;
      seed      <= SEED_INIT;
      result_ok <= 1'b0;
      attempts  <= '0;
    end else begin
      state <= state_n;
      if (adv_lfsr) seed <= lfsr_next;
      case (state)
        IDLE: if (req) att_cnt <= '0;
        RESET_GEN: begin
          done_prev <= 1'b0;
          att_cnt   <= att_cnt + 4'd1;
          cnt       <= '0;
        end
        // done_prev follows gen_done through START too, so a level left high
        // from before this attempt is not taken as a fresh edge on WAIT entry.
        START: begin
          done_prev <= gen_done;
          cnt       <= start_last ? '0 : cnt + 1'b1;
        end
        WAIT: begin
          done_prev <= gen_done;
          if (done_edge)         succ <= gen_success;
          else if (wait_timeout) succ <= 1'b0;
          else                   cnt  <= cnt + 1'b1;
        end
        // Result registers load on the way into REPORT so they are valid with the pulse.
        CHECK: begin
          if (state_n == REPORT) begin
            result_ok <= succ;
            attempts  <= att_cnt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GRID_SEQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      total_attempts <= '0;
      total_timeouts <= '0;
    end else begin
      if (state == RESET_GEN && total_attempts != 16'hFFFF)
        total_attempts <= total_attempts + 16'd1;
      if (wait_timeout && total_timeouts != 16'hFFFF)
        total_timeouts <= total_timeouts + 16'd1;
    end
  end
`else
  assign total_attempts = 16'h0;
  assign total_timeouts = 16'h0;
`endif

endmodule

// File: doc/grid_gen_sequencer.md
Name: grid_gen_sequencer

Overview:
- Controller that sequences one `grid` generator instance (either GENPATH) on behalf of a single requester.
- Drives the generator's seed, reset and rq_start. Detects done/success and retries failed or hung attempts with fresh LFSR seeds.
- Returns one result per request via a single-cycle valid pulse.
- Sits between the top-level control and the `grid` instance, replacing hand-sequenced testbench stimulus.

Parameters:
MAX_ATTEMPTS, 8, attempts per request before reporting failure (1..15)
TIMEOUT_CYCLES, 22500, cycles in WAIT without done before the attempt counts as failed (>=2)
START_PULSE, 4, cycles gen_rq_start is held high per attempt (>=1)
SEED_INIT, 8'h01, LFSR value after reset; must be nonzero

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  level request for a grid; sampled only in IDLE
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle pulse in REPORT
result_ok  out  1  final attempt succeeded; held until next REPORT
attempts  out  4  attempts used by the last request; held until next REPORT
seed  out  8  seed to the grid; stable from RESET_GEN through WAIT
gen_reset  out  1  reset to the grid
gen_rq_start  out  1  start request to the grid
gen_done  in  1  grid done
gen_success  in  1  grid success, valid with gen_done
total_attempts  out  16  lifetime attempt count (see Optional Feature)
total_timeouts  out  16  lifetime timeout count (see Optional Feature)

Behaviour:
- Reset values:
  - state=IDLE
  - busy=0, result_valid=0, result_ok=0, attempts=0
  - gen_reset=0, gen_rq_start=0
  - seed=SEED_INIT
  - internal counters=0, done_prev=0
- States and transitions:
  - IDLE: if req=1, clear attempt count and go to RESET_GEN.
  - RESET_GEN: one cycle; gen_reset=1; done_prev cleared; attempt count +1; go to START.
  - START: gen_rq_start=1 for exactly START_PULSE cycles; then go to WAIT with the wait counter at 0.
  - WAIT: done_prev<=gen_done every cycle.
    - Rising edge (gen_done=1, done_prev=0): latch gen_success, go to CHECK.
    - Else, if wait counter == TIMEOUT_CYCLES-1: latch success=0, set timeout flag, go to CHECK.
    - Else wait counter +1.
    - A done edge and the timeout in the same cycle: the done edge wins.
  - CHECK: one cycle.
    - If latched success=1, or attempt count == MAX_ATTEMPTS: go to REPORT.
    - Else advance the LFSR and go to RESET_GEN.
  - REPORT: one cycle.
    - result_valid=1; result_ok=latched success; attempts=attempt count.
    - Advance the LFSR, so the next request never reuses the seed.
    - Go to IDLE.
- Latency: req seen in IDLE at cycle 0.
  - gen_reset high in cycle 1.
  - gen_rq_start high in cycles 2..1+START_PULSE.
  - WAIT from cycle 2+START_PULSE.
  - Result: REPORT is 2 cycles after the done edge (CHECK, then REPORT).
- LFSR: 8-bit Galois, right shift, taps 0xB8.
  - next = (seed>>1) ^ (seed[0] ? 8'hB8 : 0).
  - Never reaches zero from a nonzero value.
- gen_done edges outside WAIT are ignored.
- A rising edge is required; a done held high from a previous attempt is cleared by gen_reset and done_prev.
- req in any state other than IDLE is ignored.
- If req is still high in IDLE after REPORT, a new run starts immediately.
- reset asserted in any state: all outputs take their reset values on the next edge; any attempt in progress is abandoned.

Optional Feature:
- Macro: GRID_SEQ_STATS_EN.
- Defined:
  - total_attempts increments in every RESET_GEN.
  - total_timeouts increments on every timeout exit from WAIT.
  - Both saturate at 16'hFFFF and are cleared only by reset.
- Undefined: both ports are present and tied to 16'h0; no counter flops are synthesized.

Test Plan:
- First-try success: bench model raises done+success 10 cycles after WAIT entry.
  - Seed 0x01 during the attempt.
  - result_valid pulse with result_ok=1, attempts=1, exactly 2 cycles after the done edge.
  - seed=0xB8 afterwards.
- Two failures then success: model returns success=0, 0, 1.
  - Seeds per attempt 0x01, 0xB8, 0x5C.
  - gen_reset pulsed 3 times; result_ok=1, attempts=3.
- Timeout: TIMEOUT_CYCLES=100, MAX_ATTEMPTS=8, model never raises done.
  - 8 gen_reset pulses, each attempt exactly 100 WAIT cycles.
  - result_ok=0, attempts=8.
  - total_timeouts=8 with GRID_SEQ_STATS_EN, 0 without.
- Stale done: gen_done stuck high from power-up through START.
  - No CHECK until done falls and rises again inside WAIT.
- Reset mid-WAIT: assert reset for 1 cycle at WAIT cycle 50.
  - Next cycle: busy=0, gen_rq_start=0, seed=0x01, result_valid never pulses.
- Request handling: req pulsed while busy changes nothing. req held high continuously produces back-to-back runs, the second starting at seed 0xB8.
